// File: rtl/prom_xfer_pkg.sv
// rtl/prom_xfer_pkg.sv - state codes and shared defaults for the PROM transfer FSMs
package prom_xfer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHIP_ENA = 4'd1,
    ST_SETUP    = 4'd2,
    ST_WR_PULSE = 4'd3,
    ST_WAIT_RDY = 4'd4,
    ST_DONE     = 4'd5,
    ST_ERROR    = 4'd6
  } prom_state_e;

  localparam logic [8:0]  MAX_WRDS_DEF = 9'd34;
  localparam logic [8:0]  NMAX_DEF     = 9'd10;
  localparam logic [3:0]  CE_SETTLE    = 4'd10;
  localparam logic [15:0] RDY_IGNORE   = 16'd2;

  // Final word index of a transfer; CRC adds two words to every group. 9-bit wrap is intended.
  function automatic logic [8:0] last_word(input logic crc, input logic [8:0] max_wrds,
                                           input logic [8:0] nmax);
    if (crc) return nmax * (max_wrds + 9'd2) - 9'd1;
    else     return nmax * max_wrds - 9'd1;
  endfunction

endpackage

// File: rtl/prom_write_fsm.sv
// rtl/prom_write_fsm.sv - streams the register bank into a byte-wide PROM, one strobed byte at a time
module prom_write_fsm
  import prom_xfer_pkg::*;
#(
  parameter logic [8:0]  MAX_WRDS = MAX_WRDS_DEF,
  parameter logic [8:0]  NMAX     = NMAX_DEF,
  parameter logic [3:0]  TSU      = 4'd3,
  parameter logic [3:0]  TWP      = 4'd4,
  parameter logic [15:0] TMO      = 16'd50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FF2PROM,
  input  logic [8:0] CNT,
  input  logic       ECC,
  input  logic       CRC,
  input  logic       PROM_RDY,
  output logic       CE,
  output logic       OE,
  output logic       WE,
  output logic [2:0] BSEL,
  output logic       INC,
  output logic       RST_CNT,
  output logic       XFER_DONE,
  output logic       ERR,
  output logic [3:0] PWR_STATE
);

  localparam logic [8:0] LAST_PLAIN = last_word(1'b0, MAX_WRDS, NMAX);
  localparam logic [8:0] LAST_CRC   = last_word(1'b1, MAX_WRDS, NMAX);

  prom_state_e state_q, state_d;
  logic [3:0]  tmr_q, tmr_d;
  logic [15:0] to_q, to_d;
  logic [2:0]  bidx_q, bidx_d;
  logic        ecc_q, ecc_d, crc_q, crc_d;
  logic        ce_q, ce_d, we_q, we_d, inc_q, inc_d;
  logic        rst_cnt_q, rst_cnt_d, done_q, done_d, err_q, err_d;
  logic [2:0]  bsel_q, bsel_d;
  logic [2:0]  last_byte;
  logic [8:0]  last_cnt;
  logic        rdy_ok;

  always_comb begin
    state_d   = state_q;
    tmr_d     = 4'd0;
    to_d      = 16'd0;
    bidx_d    = bidx_q;
    ecc_d     = ecc_q;
    crc_d     = crc_q;
    inc_d     = 1'b0;
    last_byte = ecc_q ? 3'd5 : 3'd1;
    last_cnt  = crc_q ? LAST_CRC : LAST_PLAIN;
    rdy_ok    = PROM_RDY && (to_q >= RDY_IGNORE);

    // Timers default to zero, so any state change clears them.
    case (state_q)
      ST_IDLE: begin
        bidx_d = 3'd0;
        if (FF2PROM) begin
          state_d = ST_CHIP_ENA;
          ecc_d   = ECC;
          crc_d   = CRC;
        end
      end
      ST_CHIP_ENA: begin
        if (tmr_q == CE_SETTLE) state_d = ST_SETUP;
        else                    tmr_d   = tmr_q + 4'd1;
      end
      ST_SETUP: begin
        if (tmr_q == TSU - 4'd1) state_d = ST_WR_PULSE;
        else                     tmr_d   = tmr_q + 4'd1;
      end
      ST_WR_PULSE: begin
        if (tmr_q == TWP - 4'd1) state_d = ST_WAIT_RDY;
        else                     tmr_d   = tmr_q + 4'd1;
      end
      ST_WAIT_RDY: begin
        // A ready in the timeout cycle still counts as success.
        if (rdy_ok) begin
          if (bidx_q < last_byte) begin
            bidx_d  = bidx_q + 3'd1;
            state_d = ST_SETUP;
          end else begin
            inc_d   = 1'b1;
            bidx_d  = 3'd0;
            state_d = (CNT == last_cnt) ? ST_DONE : ST_SETUP;
          end
        end else if (to_q == TMO - 16'd1) begin
          state_d = ST_ERROR;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (!FF2PROM) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ce_d      = (state_d == ST_CHIP_ENA) || (state_d == ST_SETUP) ||
                (state_d == ST_WR_PULSE) || (state_d == ST_WAIT_RDY);
    we_d      = (state_d == ST_WR_PULSE);
    rst_cnt_d = (state_d == ST_IDLE) || (state_d == ST_CHIP_ENA);
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERROR);
    // The byte mux only moves on Setup entry, never under an active strobe.
    bsel_d    = bsel_q;
    if (state_d == ST_IDLE)                               bsel_d = 3'd0;
    else if ((state_d == ST_SETUP) && (state_q != ST_SETUP)) bsel_d = bidx_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      tmr_q     <= 4'd0;
      to_q      <= 16'd0;
      bidx_q    <= 3'd0;
      ecc_q     <= 1'b0;
      crc_q     <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      bsel_q    <= 3'd0;
      inc_q     <= 1'b0;
      rst_cnt_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      to_q      <= to_d;
      bidx_q    <= bidx_d;
      ecc_q     <= ecc_d;
      crc_q     <= crc_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      bsel_q    <= bsel_d;
      inc_q     <= inc_d;
      rst_cnt_q <= rst_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign CE        = ce_q;
  assign OE        = 1'b0;
  assign WE        = we_q;
  assign BSEL      = bsel_q;
  assign INC       = inc_q;
  assign RST_CNT   = rst_cnt_q;
  assign XFER_DONE = done_q;
  assign ERR       = err_q;
  assign PWR_STATE = state_q;

endmodule

// File: tb/tb_prom_write_fsm.sv
// tb/tb_prom_write_fsm.sv - scoreboard bench for prom_write_fsm with a word counter and PROM ready model
module tb_prom_write_fsm;

  localparam int MAX_WRDS_P = 2;
  localparam int NMAX_P     = 1;
  localparam int TSU_P      = 3;
  localparam int TWP_P      = 4;
  localparam int TMO_P      = 100;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FF2PROM;
  logic       ECC;
  logic       CRC;
  logic       PROM_RDY;
  logic [8:0] CNT = 9'd0;
  logic       CE, OE, WE, INC, RST_CNT, XFER_DONE, ERR;
  logic [2:0] BSEL;
  logic [3:0] PWR_STATE;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // 0: ready 5 cycles after the strobe falls, 1: stuck low, 2: stuck high
  int         rdy_mode = 0;
  logic [3:0] busy = 4'd0;

  prom_write_fsm #(
    .MAX_WRDS(9'(MAX_WRDS_P)), .NMAX(9'(NMAX_P)), .TSU(4'(TSU_P)),
    .TWP(4'(TWP_P)), .TMO(16'(TMO_P))
  ) dut (
    .CLK(CLK), .RST(RST), .FF2PROM(FF2PROM), .CNT(CNT), .ECC(ECC), .CRC(CRC),
    .PROM_RDY(PROM_RDY), .CE(CE), .OE(OE), .WE(WE), .BSEL(BSEL), .INC(INC),
    .RST_CNT(RST_CNT), .XFER_DONE(XFER_DONE), .ERR(ERR), .PWR_STATE(PWR_STATE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST_CNT)  CNT <= 9'd0;
    else if (INC) CNT <= CNT + 9'd1;
  end

  always @(posedge CLK) begin
    if (WE)                busy <= 4'd0;
    else if (busy != 4'hF) busy <= busy + 4'd1;
  end

  assign PROM_RDY = (rdy_mode == 2) || ((rdy_mode == 0) && (busy >= 4'd5));

  task automatic run_xfer(input logic ecc, input logic crc, input int wait_exp, input bit exp_err);
    int nbytes, nwords, lastw, st, prev, run, we_run, incs, exp_b, exp_len;
    bit fin, inc_prev, flipped;
    logic [2:0] bsel_w;
    nbytes = ecc ? 6 : 2;
    nwords = crc ? NMAX_P * (MAX_WRDS_P + 2) : NMAX_P * MAX_WRDS_P;
    lastw  = nwords - 1;
    exp_q.delete();
    if (exp_err) exp_q.push_back(0);
    else for (int w = 0; w < nwords; w++) for (int b = 0; b < nbytes; b++) exp_q.push_back(b);
    @(negedge CLK);
    ECC = ecc; CRC = crc; FF2PROM = 1'b1;
    prev = int'(PWR_STATE); run = 0; we_run = 0; incs = 0;
    inc_prev = 1'b0; fin = 1'b0; flipped = 1'b0; bsel_w = 3'd0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge CLK);
      st = int'(PWR_STATE);
      checks++;
      if (WE !== (st == 3)) begin
        errors++; $display("FAIL we_vs_state: WE=%0b state=%0d", WE, st);
      end
      if (INC) begin
        incs++; checks++;
        if (inc_prev) begin errors++; $display("FAIL inc_width: INC high two cycles"); end
      end
      inc_prev = INC;
      if (st == 3 && WE) we_run++;
      if (st != prev) begin
        exp_len = -1;
        case (prev)
          1: exp_len = 11;
          2: exp_len = TSU_P;
          3: exp_len = TWP_P;
          4: exp_len = (st == 6) ? TMO_P : wait_exp;
          default: exp_len = -1;
        endcase
        if (exp_len >= 0) begin
          checks++;
          if (run !== exp_len) begin
            errors++; $display("FAIL state%0d_len: got %0d cycles expected %0d", prev, run, exp_len);
          end
        end
        if (prev == 3) begin
          checks++;
          if (we_run !== TWP_P || BSEL !== bsel_w) begin
            errors++;
            $display("FAIL we_pulse: width %0d bsel %0d expected width %0d bsel %0d", we_run, BSEL, TWP_P, bsel_w);
          end
        end
        if (st == 3) begin
          bsel_w = BSEL; we_run = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL sb_underflow: BSEL=%0d with no expected byte", BSEL);
          end else begin
            exp_b = exp_q.pop_front();
            if (int'(BSEL) !== exp_b) begin
              errors++; $display("FAIL sb_bsel: got %0d expected %0d", BSEL, exp_b);
            end
          end
        end
        if (st == 1 && !flipped) begin
          ECC = ~ecc; CRC = ~crc; flipped = 1'b1;
        end
        if (st == 5) begin
          checks++;
          if (CNT !== 9'(lastw) || XFER_DONE !== 1'b1) begin
            errors++; $display("FAIL done_entry: CNT=%0d XFER_DONE=%0b expected CNT=%0d XFER_DONE=1", CNT, XFER_DONE, lastw);
          end
          fin = 1'b1;
        end
        if (st == 6) fin = 1'b1;
        prev = st; run = 1;
      end else begin
        run++;
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL xfer_timeout: state %0d after 5000 cycles", PWR_STATE); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d bytes not written expected 0", exp_q.size()); end
    checks++;
    if (incs !== (exp_err ? 0 : nwords)) begin
      errors++; $display("FAIL inc_count: got %0d expected %0d", incs, exp_err ? 0 : nwords);
    end
    if (exp_err) begin
      checks++;
      if (PWR_STATE !== 4'd6 || ERR !== 1'b1 || CE !== 1'b0 || XFER_DONE !== 1'b0) begin
        errors++; $display("FAIL error_state: st=%0d ERR=%0b CE=%0b DONE=%0b expected 6 1 0 0", PWR_STATE, ERR, CE, XFER_DONE);
      end
    end else begin
      @(negedge CLK);
      checks++;
      if (CNT !== 9'(nwords) || CE !== 1'b0 || ERR !== 1'b0 || PWR_STATE !== 4'd5) begin
        errors++; $display("FAIL done_hold: CNT=%0d CE=%0b ERR=%0b st=%0d expected %0d 0 0 5", CNT, CE, ERR, PWR_STATE, nwords);
      end
    end
  endtask

  task automatic release_req();
    @(negedge CLK);
    FF2PROM = 1'b0;
    @(negedge CLK);
    checks++;
    if (PWR_STATE !== 4'd0 || ERR !== 1'b0 || XFER_DONE !== 1'b0 || RST_CNT !== 1'b1) begin
      errors++; $display("FAIL release: st=%0d ERR=%0b DONE=%0b RST_CNT=%0b expected 0 0 0 1", PWR_STATE, ERR, XFER_DONE, RST_CNT);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; FF2PROM = 1'b0; ECC = 1'b0; CRC = 1'b0; rdy_mode = 0;
    #2;
    checks++;
    if ({CE, OE, WE, BSEL, INC, RST_CNT, XFER_DONE, ERR} !== 10'b0000_0001_00 || PWR_STATE !== 4'd0) begin
      errors++; $display("FAIL reset_outputs: CE%0b OE%0b WE%0b BSEL%0d INC%0b RSTC%0b DONE%0b ERR%0b st%0d",
                         CE, OE, WE, BSEL, INC, RST_CNT, XFER_DONE, ERR, PWR_STATE);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (PWR_STATE !== 4'd0 || CE !== 1'b0 || RST_CNT !== 1'b1) begin
      errors++; $display("FAIL idle_hold: st=%0d CE=%0b RST_CNT=%0b expected 0 0 1", PWR_STATE, CE, RST_CNT);
    end
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    run_xfer(1'b0, 1'b0, 6, 1'b0);
    release_req();
  endtask

  task automatic test_ecc();
    rdy_mode = 0;
    run_xfer(1'b1, 1'b0, 6, 1'b0);
    release_req();
  endtask

  task automatic test_crc_rdy_early();
    rdy_mode = 2;
    run_xfer(1'b0, 1'b1, 3, 1'b0);
    release_req();
  endtask

  task automatic test_timeout();
    rdy_mode = 1;
    run_xfer(1'b0, 1'b0, 0, 1'b1);
    repeat (5) @(negedge CLK);
    checks++;
    if (PWR_STATE !== 4'd6 || ERR !== 1'b1) begin
      errors++; $display("FAIL error_sticky: st=%0d ERR=%0b expected 6 1", PWR_STATE, ERR);
    end
    release_req();
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    rdy_mode = 0;
    seen = 1'b0;
    @(negedge CLK);
    FF2PROM = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (WE) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wr_pulse_seen: WE never rose expected 1"); end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (WE !== 1'b0 || RST_CNT !== 1'b1 || PWR_STATE !== 4'd0 || CE !== 1'b0) begin
      errors++; $display("FAIL async_reset: WE=%0b RST_CNT=%0b st=%0d CE=%0b expected 0 1 0 0", WE, RST_CNT, PWR_STATE, CE);
    end
    FF2PROM = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (PWR_STATE !== 4'd0 || BSEL !== 3'd0) begin
      errors++; $display("FAIL post_reset: st=%0d BSEL=%0d expected 0 0", PWR_STATE, BSEL);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    rdy_mode = 0;
    run_xfer(1'b0, 1'b0, 6, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (PWR_STATE !== 4'd5 || WE !== 1'b0 || XFER_DONE !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL done_no_rewrite: %0d bad cycles expected 0", bad); end
    release_req();
    run_xfer(1'b0, 1'b0, 6, 1'b0);
    release_req();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ecc();
    test_crc_rdy_early();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
